nios2_oci_trace_capture: RTL and testbench

Parametrised, synthesisable capture buffer for Nios II OCI data-capture-trace (DCT) words. It sits beside the OCI debug logic, packs each valid trace word with its count into an on-chip FIFO, and lets a debug host drain it after the test signals completion. Full handling is selectable: drop-new or overwrite-oldest (circular). Status outputs report buffer level, overflow, dropped entries and end-of-test completion.

---
 rtl/nios2_oci_trace_capture.sv | 115 +++++++++++
 tb/tb_nios2_oci_trace_capture.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_oci_trace_capture.sv
// Capture FIFO for Nios II OCI data-capture-trace words with drop-new or overwrite-oldest
// full handling, followed by a host drain phase and a terminal DONE state.
module nios2_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
  parameter int DROP_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_W-1:0]           dct_buffer,
  input  logic [CNT_W-1:0]            dct_count,
  input  logic                        dct_valid,
  input  logic                        test_ending,
  input  logic                        test_has_ended,
  input  logic                        rd_req,
  output logic [CNT_W+DATA_W-1:0]     rd_data,
  output logic                        rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_count,
  output logic                        capturing,
  output logic                        done
);

  localparam int  PTR_W = $clog2(DEPTH);
  localparam int  LVL_W = $clog2(DEPTH+1);
  localparam int  ENT_W = CNT_W + DATA_W;
  localparam bit  WRAP  = (WRAP_MODE != 0);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ENT_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_ended;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop;
  logic [ENT_W-1:0]    r_rd_data;
  logic                r_rd_valid;

  logic w_full;
  logic w_wr_en;
  logic w_rd_en;
  logic w_store;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_wr_en = (r_state == ST_CAPTURE) && dct_valid && (dct_count != '0);
  assign w_rd_en = (r_state != ST_DONE) && rd_req && (r_level != '0);
  // A write into a full FIFO counts as a loss unless a pop frees the slot this cycle;
  // in wrap mode the loss is the oldest entry, so the read pointer moves with the write.
  assign w_drop  = w_wr_en && w_full && !w_rd_en;
  assign w_store = w_wr_en && (!w_drop || WRAP);
  assign w_pop   = w_rd_en || (w_drop && WRAP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CAPTURE: if (test_ending || test_has_ended) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if ((r_level == '0) && (r_ended || test_has_ended)) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_DONE;
      default:    w_state_nxt = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wptr] <= {dct_count, dct_buffer};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_CAPTURE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_ended    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ended    <= r_ended | test_has_ended;
      r_rd_valid <= w_rd_en;
      if (w_rd_en) r_rd_data <= r_mem[r_rptr];
      if (w_store) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      if (w_store && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_store) r_level <= r_level - 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop;
  assign capturing  = (r_state == ST_CAPTURE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed bench: one drop-mode and one wrap-mode capture buffer driven by the same stimulus.
module tb_nios2_oci_trace_capture;

  localparam int DATA_W = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;
  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int ENT_W  = CNT_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] dct_buffer = '0;
  logic [CNT_W-1:0]  dct_count = '0;
  logic              dct_valid = 1'b0;
  logic              test_ending = 1'b0;
  logic              test_has_ended = 1'b0;
  logic              rd_req = 1'b0;

  logic [ENT_W-1:0]  d_rd_data,   w_rd_data;
  logic              d_rd_valid,  w_rd_valid;
  logic [LVL_W-1:0]  d_level,     w_level;
  logic              d_overflow,  w_overflow;
  logic [DROP_W-1:0] d_drop,      w_drop;
  logic              d_capturing, w_capturing;
  logic              d_done,      w_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nios2_oci_trace_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
                            .WRAP_MODE(0), .DROP_W(DROP_W)) u_drop (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_req(rd_req), .rd_data(d_rd_data), .rd_valid(d_rd_valid), .level(d_level),
    .overflow(d_overflow), .drop_count(d_drop), .capturing(d_capturing), .done(d_done));

  nios2_oci_trace_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
                            .WRAP_MODE(1), .DROP_W(DROP_W)) u_wrap (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_req(rd_req), .rd_data(w_rd_data), .rd_valid(w_rd_valid), .level(w_level),
    .overflow(w_overflow), .drop_count(w_drop), .capturing(w_capturing), .done(w_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ENT_W-1:0] ent(input int cnt, input int pay);
    return {CNT_W'(cnt), DATA_W'(pay)};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_req = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (d_rd_data !== '0 || d_rd_valid !== 1'b0 || d_level !== '0 || d_overflow !== 1'b0 ||
        d_drop !== '0 || d_capturing !== 1'b1 || d_done !== 1'b0)
      $display("FAIL reset_state: data=%h valid=%b level=%0d ovf=%b drop=%0d cap=%b done=%b, want 0/0/0/0/0/1/0",
               d_rd_data, d_rd_valid, d_level, d_overflow, d_drop, d_capturing, d_done);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    for (int i = 0; i < 4; i++) begin
      dct_valid = 1'b1; dct_count = '0; dct_buffer = DATA_W'(32'h77 + i);
      tick();
    end
    dct_valid = 1'b0;
    tick();
    n_total++;
    if (d_level !== '0 || d_overflow !== 1'b0 || d_drop !== '0)
      $display("FAIL zero_count: level=%0d ovf=%b drop=%0d, want 0/0/0", d_level, d_overflow, d_drop);
    else n_pass++;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 5; i++) begin
      dct_valid = 1'b1; dct_count = CNT_W'(i); dct_buffer = DATA_W'(i);
      tick();
    end
    dct_valid = 1'b0;
    n_total++;
    if (d_level !== LVL_W'(5)) $display("FAIL basic_level_fill: got %0d want 5", d_level);
    else n_pass++;
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    n_total++;
    if (d_capturing !== 1'b0 || d_done !== 1'b0)
      $display("FAIL basic_to_drain: cap=%b done=%b want 0/0", d_capturing, d_done);
    else n_pass++;
    // Back-to-back pops: one entry per cycle
    rd_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_total++;
      if (d_rd_valid !== 1'b1 || d_rd_data !== ent(i, i) || d_level !== LVL_W'(5 - i))
        $display("FAIL basic_pop%0d: valid=%b data=%h level=%0d want 1/%h/%0d",
                 i, d_rd_valid, d_rd_data, d_level, ent(i, i), 5 - i);
      else n_pass++;
    end
    rd_req = 1'b0;
    tick();
    n_total++;
    if (d_rd_valid !== 1'b0 || d_rd_data !== ent(5, 5) || d_done !== 1'b0)
      $display("FAIL basic_hold: valid=%b data=%h done=%b want 0/%h/0",
               d_rd_valid, d_rd_data, d_done, ent(5, 5));
    else n_pass++;
    test_has_ended = 1'b1;
    tick();
    test_has_ended = 1'b0;
    n_total++;
    if (d_done !== 1'b1 || d_capturing !== 1'b0)
      $display("FAIL basic_done: done=%b cap=%b want 1/0", d_done, d_capturing);
    else n_pass++;
    // DONE ignores both writes and reads
    dct_valid = 1'b1; dct_count = CNT_W'(3); dct_buffer = DATA_W'(32'h55);
    rd_req = 1'b1;
    tick();
    dct_valid = 1'b0; rd_req = 1'b0;
    n_total++;
    if (d_level !== '0 || d_rd_valid !== 1'b0 || d_done !== 1'b1)
      $display("FAIL done_ignores: level=%0d valid=%b done=%b want 0/0/1", d_level, d_rd_valid, d_done);
    else n_pass++;
  endtask

  task automatic test_drop_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      dct_valid = 1'b1; dct_count = CNT_W'(i % 15 + 1); dct_buffer = DATA_W'(i);
      tick();
    end
    dct_valid = 1'b0;
    n_total++;
    if (d_level !== LVL_W'(16) || d_drop !== DROP_W'(4) || d_overflow !== 1'b1)
      $display("FAIL dropmode_status: level=%0d drop=%0d ovf=%b want 16/4/1", d_level, d_drop, d_overflow);
    else n_pass++;
    n_total++;
    if (w_level !== LVL_W'(16) || w_drop !== DROP_W'(4) || w_overflow !== 1'b1)
      $display("FAIL wrapmode_status: level=%0d drop=%0d ovf=%b want 16/4/1", w_level, w_drop, w_overflow);
    else n_pass++;
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_total++;
      if (d_rd_valid !== 1'b1 || d_rd_data !== ent(i % 15 + 1, i))
        $display("FAIL dropmode_pop%0d: valid=%b data=%h want 1/%h", i, d_rd_valid, d_rd_data, ent(i % 15 + 1, i));
      else n_pass++;
      n_total++;
      if (w_rd_valid !== 1'b1 || w_rd_data !== ent((i + 4) % 15 + 1, i + 4))
        $display("FAIL wrapmode_pop%0d: valid=%b data=%h want 1/%h", i, w_rd_valid, w_rd_data,
                 ent((i + 4) % 15 + 1, i + 4));
      else n_pass++;
    end
    rd_req = 1'b0;
    n_total++;
    if (d_level !== '0 || w_level !== '0)
      $display("FAIL drain_empty: drop_level=%0d wrap_level=%0d want 0/0", d_level, w_level);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_req = 1'b1;
    tick();
    n_total++;
    if (d_rd_valid !== 1'b0) $display("FAIL empty_read: valid=%b want 0", d_rd_valid);
    else n_pass++;
    // Empty read with a simultaneous write: write lands, read is ignored
    dct_valid = 1'b1; dct_count = CNT_W'(2); dct_buffer = DATA_W'(32'h100);
    tick();
    rd_req = 1'b0;
    n_total++;
    if (d_rd_valid !== 1'b0 || d_level !== LVL_W'(1))
      $display("FAIL empty_read_write: valid=%b level=%0d want 0/1", d_rd_valid, d_level);
    else n_pass++;
    for (int i = 1; i < 16; i++) begin
      dct_buffer = DATA_W'(32'h100 + i);
      tick();
    end
    n_total++;
    if (d_level !== LVL_W'(16) || w_level !== LVL_W'(16))
      $display("FAIL full_fill: drop_level=%0d wrap_level=%0d want 16/16", d_level, w_level);
    else n_pass++;
    dct_buffer = DATA_W'(32'h200);
    rd_req = 1'b1;
    tick();
    dct_valid = 1'b0; rd_req = 1'b0;
    n_total++;
    if (d_level !== LVL_W'(16) || d_drop !== '0 || d_overflow !== 1'b0 ||
        d_rd_valid !== 1'b1 || d_rd_data !== ent(2, 32'h100))
      $display("FAIL full_rw_drop: level=%0d drop=%0d ovf=%b valid=%b data=%h want 16/0/0/1/%h",
               d_level, d_drop, d_overflow, d_rd_valid, d_rd_data, ent(2, 32'h100));
    else n_pass++;
    n_total++;
    if (w_level !== LVL_W'(16) || w_drop !== '0 || w_overflow !== 1'b0 ||
        w_rd_valid !== 1'b1 || w_rd_data !== ent(2, 32'h100))
      $display("FAIL full_rw_wrap: level=%0d drop=%0d ovf=%b valid=%b data=%h want 16/0/0/1/%h",
               w_level, w_drop, w_overflow, w_rd_valid, w_rd_data, ent(2, 32'h100));
    else n_pass++;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n_total++;
    if (d_rd_data !== ent(2, 32'h101) || d_level !== LVL_W'(15))
      $display("FAIL full_rw_next: data=%h level=%0d want %h/15", d_rd_data, d_level, ent(2, 32'h101));
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      dct_valid = 1'b1; dct_count = CNT_W'(1); dct_buffer = DATA_W'(32'h300 + i);
      tick();
    end
    dct_valid = 1'b0;
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    rd_req = 1'b1;
    tick(); tick(); tick();
    rd_req = 1'b0;
    n_total++;
    if (d_level !== LVL_W'(7) || d_capturing !== 1'b0)
      $display("FAIL pre_reset: level=%0d cap=%b want 7/0", d_level, d_capturing);
    else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_total++;
    if (d_rd_data !== '0 || d_rd_valid !== 1'b0 || d_level !== '0 || d_overflow !== 1'b0 ||
        d_drop !== '0 || d_capturing !== 1'b1 || d_done !== 1'b0)
      $display("FAIL async_reset: data=%h valid=%b level=%0d ovf=%b drop=%0d cap=%b done=%b, want 0/0/0/0/0/1/0",
               d_rd_data, d_rd_valid, d_level, d_overflow, d_drop, d_capturing, d_done);
    else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    n_total++;
    if (d_capturing !== 1'b1 || d_level !== '0)
      $display("FAIL post_release: cap=%b level=%0d want 1/0", d_capturing, d_level);
    else n_pass++;
    dct_valid = 1'b1; dct_count = CNT_W'(3); dct_buffer = DATA_W'(32'h3ABC);
    tick();
    dct_valid = 1'b0;
    n_total++;
    if (d_level !== LVL_W'(1)) $display("FAIL post_reset_write: level=%0d want 1", d_level);
    else n_pass++;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n_total++;
    if (d_rd_valid !== 1'b1 || d_rd_data !== ent(3, 32'h3ABC))
      $display("FAIL post_reset_read: valid=%b data=%h want 1/%h", d_rd_valid, d_rd_data, ent(3, 32'h3ABC));
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_count();
    test_basic();
    test_drop_wrap();
    test_back_to_back();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
